instruction_fetch_queue: RTL and testbench
==========================================

Name: instruction_fetch_queue

Overview:
- Front-end stage directly upstream of the single-cycle CPU datapath.
- Issues word fetches to instruction memory over a ready/valid request channel and accepts in-order responses.
- Buffers fetched words with their PCs in a small queue and hands one instruction per cycle to decode over a valid/ready handshake.
- On a taken branch, jump, JR or JAL redirect from the CPU, flushes all buffered and in-flight fetches and restarts at the new PC.

Parameters:
- DEPTH, 4, queue entries; also the maximum of (queued + in-flight) fetches. Power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_resp_valid  input  1  one-cycle pulse; response data valid; in order, ≥1 cycle after request.
- imem_resp_data  input  32  fetched instruction word.
- instr_valid  output  1  queue head valid.
- instr_ready  input  1  decode consumes head this cycle.
- instr  output  32  head instruction word.
- instr_pc  output  32  PC of head instruction.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  32  restart address; bits [1:0] are ignored and forced to 0.

Behaviour:
- State:
  - fetch_pc: next request address.
  - resp_pc: PC tag for the next accepted response.
  - count: queue occupancy, 0..DEPTH.
  - outstanding: issued but not yet responded, 0..DEPTH.
  - discard: responses still to drop, ≤ outstanding.
- Reset values (async, while reset=0):
  - fetch_pc = resp_pc = RESET_PC.
  - count = outstanding = discard = 0.
  - imem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0.
- Request channel:
  - imem_req_valid = !redirect && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - Handshake (valid && ready): fetch_pc += 4 (wraps modulo 2^32); outstanding += 1.
  - Address is stable while valid && !ready.
- Response channel, on imem_resp_valid:
  - outstanding -= 1.
  - If discard > 0: discard -= 1 and the word is dropped.
  - Otherwise: push {imem_resp_data, resp_pc}; resp_pc += 4.
- Output channel:
  - instr_valid = (count != 0); instr and instr_pc show the head entry combinationally from queue storage.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push into a full queue cannot occur, because the credit rule reserves a slot per request.
- Redirect (registered effect, takes priority over every other event that cycle):
  - count = 0; any pop that cycle is ignored.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - No request is issued that cycle.
  - discard = outstanding after this cycle's response decrement, so every in-flight word, including one arriving in the redirect cycle, is dropped.
  - First request to the new PC: the cycle after redirect.
- Latency:
  - Request accepted at cycle N, response at N+k: instr_valid rises at N+k+1 if the queue was empty (response is registered into the queue).
  - Steady state with 1-cycle memory: one instruction per cycle.
- Back-to-back redirects: the last one wins; discard accumulates correctly because it is recomputed from outstanding.
- imem_resp_valid with outstanding == 0: protocol violation. Ignore it (no state change) and flag it with a simulation assertion.
- Reset asserted mid-operation: all counters clear immediately; later responses to pre-reset requests are not tracked (memory must also be reset).

Decomposition:
- Shared package/constants header:
  - PC_INCR = 4.
  - WORD_W = 32.
  - Width function for counters: clog2(DEPTH+1).
- One natural sub-module: fetch_fifo. Synchronous DEPTH-entry FIFO of 64-bit {pc, instr} entries, with push, pop, flush and count outputs, using the same clk and active-low async reset.
- Top level holds the credit, redirect and discard control.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr+0x100 as data, instr_ready=1 → requests to 0x0, 0x4, 0x8…; instr/instr_pc = 0x100/0x0, 0x104/0x4, … one per cycle from cycle 2.
- instr_ready=0, memory always ready → exactly 4 requests issued (0x0–0xC), then imem_req_valid=0; count=4. Raise instr_ready → entries drain in order and fetching resumes at 0x10.
- 3-cycle memory latency, 3 requests outstanding, redirect with redirect_pc=0x203 → queue empties; the 3 late responses are dropped; next request is 0x200; first delivered instr_pc = 0x200.
- Redirect in the same cycle as imem_resp_valid and a pop → that response is dropped, the pop has no effect, count=0, discard = remaining outstanding.
- imem_req_ready held low for 5 cycles → imem_req_addr is held at the same value with valid high; no state change until ready.
- Assert reset mid-stream with 2 entries queued → instr_valid=0 immediately (asynchronous); after release, first request is RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
package instruction_fetch_queue_pkg;

    localparam int                WORD_W  = 32;
    localparam int                ENTRY_W = 2 * WORD_W;
    localparam logic [WORD_W-1:0] PC_INCR = 32'd4;

    // Counters must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// DEPTH-entry queue of {pc, instr} entries; head is visible combinationally.
module fetch_fifo
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] push_data,
    output logic [ENTRY_W-1:0] head_data,
    output logic [CW-1:0]      count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        do_push  = push && !flush && (count_q != CW'(DEPTH));
        do_pop   = pop && !flush && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: credit-limited memory requests, in-order response tagging,
// and redirect flush with discard of in-flight words.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [WORD_W-1:0] imem_resp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc
);

    localparam int CW = cnt_w(DEPTH);

    logic [WORD_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [WORD_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [CW-1:0]      discard_q, discard_d;
    logic [CW-1:0]      count;
    logic [CW:0]        in_use;
    logic [WORD_W-1:0]  redirect_base;
    logic [ENTRY_W-1:0] head;
    logic               req_fire, resp_ok, push, pop;

    always_comb begin
        redirect_base = {redirect_pc[WORD_W-1:2], 2'b00};
        // Every queued or in-flight word holds a slot, so a response can never overflow.
        in_use         = {1'b0, count} + {1'b0, outstanding_q};
        imem_req_valid = reset && !redirect && (in_use < (CW+1)'(DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        resp_ok        = imem_resp_valid && (outstanding_q != '0);
        push           = resp_ok && (discard_q == '0) && !redirect;
        pop            = instr_valid && instr_ready && !redirect;
        outstanding_d  = outstanding_q + CW'(req_fire) - CW'(resp_ok);
        discard_d      = discard_q;
        fetch_pc_d     = fetch_pc_q;
        resp_pc_d      = resp_pc_q;
        if (redirect) begin
            discard_d  = outstanding_d;
            fetch_pc_d = redirect_base;
            resp_pc_d  = redirect_base;
        end else begin
            if (resp_ok && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_INCR;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + PC_INCR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data ({resp_pc_q, imem_resp_data}),
        .head_data (head),
        .count     (count)
    );

    assign imem_req_addr = fetch_pc_q;
    assign instr_valid   = (count != '0);
    assign instr         = head[WORD_W-1:0];
    assign instr_pc      = head[ENTRY_W-1:WORD_W];

    resp_without_request: assert property (
        @(posedge clk) disable iff (!reset) !(imem_resp_valid && (outstanding_q == '0))
    );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench with a latency-configurable memory model and an
// in-order scoreboard of expected {pc, instr} deliveries.
module tb_instruction_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    int          checks   = 0;
    int          failures = 0;
    int          cyc;
    int          lat;
    int          n_req;
    int          n_pop;
    int          first_pop_cyc;
    logic [31:0] first_pop_pc;
    logic [31:0] exp_addr;
    logic [31:0] held_addr;
    logic [63:0] exp_e;
    logic [63:0] sb[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    instruction_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, score request/pop, advance.
    task automatic step();
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_addr[0] + 32'h100;
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        if (redirect) begin
            check("no_req_in_redirect", 64'(imem_req_valid), 64'd0);
            sb.delete();
            exp_addr      = {redirect_pc[31:2], 2'b00};
            first_pop_cyc = -1;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", 64'(imem_req_addr), 64'(exp_addr));
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
                sb.push_back({exp_addr, exp_addr + 32'h100});
                exp_addr = exp_addr + 32'd4;
                n_req++;
            end
            if (instr_valid && instr_ready) begin
                check("pop_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    check("pop_pc", 64'(instr_pc), 64'(exp_e[63:32]));
                    check("pop_instr", 64'(instr), 64'(exp_e[31:0]));
                end
                if (first_pop_cyc < 0) begin
                    first_pop_cyc = cyc;
                    first_pop_pc  = instr_pc;
                end
                n_pop++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        pend_addr.delete();
        pend_due.delete();
        sb.delete();
        exp_addr      = RESET_PC;
        n_req         = 0;
        n_pop         = 0;
        first_pop_cyc = -1;
        first_pop_pc  = 32'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic drain(input string tag);
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            step();
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        instr_ready     = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        lat             = 1;
        @(posedge clk);
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_instr_pc", 64'(instr_pc), 64'd0);

        // Streaming with 1-cycle memory.
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat            = 1;
        repeat (12) step();
        check("t1_first_pop_cyc", 64'(first_pop_cyc), 64'd2);
        check("t1_pops", 64'(n_pop), 64'd10);
        check("t1_reqs", 64'(n_req), 64'd12);
        drain("t1_drain");

        // Decode stalled: credit limit caps requests at DEPTH.
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        repeat (8) step();
        check("t2_reqs", 64'(n_req), 64'd4);
        check("t2_req_valid_off", 64'(imem_req_valid), 64'd0);
        check("t2_instr_valid", 64'(instr_valid), 64'd1);
        check("t2_head_instr", 64'(instr), 64'h100);
        check("t2_head_pc", 64'(instr_pc), 64'h0);
        instr_ready = 1'b1;
        repeat (6) step();
        drain("t2_drain");

        // Redirect with 3 requests in flight on slow memory.
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat            = 4;
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        redirect = 1'b0;
        check("t3_flushed", 64'(instr_valid), 64'd0);
        check("t3_next_addr", 64'(imem_req_addr), 64'h200);
        repeat (12) step();
        check("t3_first_pc", 64'(first_pop_pc), 64'h200);
        check("t3_first_cyc", 64'(first_pop_cyc), 64'd9);
        drain("t3_drain");

        // Redirect coinciding with a response and a pop.
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat            = 2;
        repeat (5) step();
        check("t4_pop_pending", 64'(instr_valid), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        step();
        redirect = 1'b0;
        check("t4_empty_c6", 64'(instr_valid), 64'd0);
        step();
        check("t4_empty_c7", 64'(instr_valid), 64'd0);
        repeat (8) step();
        check("t4_first_pc", 64'(first_pop_pc), 64'h400);
        check("t4_first_cyc", 64'(first_pop_cyc), 64'd9);
        drain("t4_drain");

        // Memory not ready: address held with valid high.
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat            = 1;
        repeat (4) step();
        imem_req_ready = 1'b0;
        held_addr      = imem_req_addr;
        check("t5_held_addr", 64'(held_addr), 64'h10);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_stall_valid", 64'(imem_req_valid), 64'd1);
            check("t5_stall_addr", 64'(imem_req_addr), 64'(held_addr));
        end
        imem_req_ready = 1'b1;
        repeat (6) step();
        drain("t5_drain");

        // Asynchronous reset with two entries queued.
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        lat            = 1;
        repeat (3) step();
        check("t6_queued", 64'(instr_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("t6_async_valid", 64'(instr_valid), 64'd0);
        check("t6_async_req", 64'(imem_req_valid), 64'd0);
        check("t6_async_instr", 64'(instr), 64'd0);
        do_reset();
        #1;
        check("t6_restart_valid", 64'(imem_req_valid), 64'd1);
        check("t6_restart_addr", 64'(imem_req_addr), 64'(RESET_PC));
        instr_ready = 1'b1;
        repeat (6) step();

        // Back-to-back redirects; last wins, and PC wraps past 2^32.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0500;
        step();
        redirect_pc = 32'hFFFF_FFF9;
        step();
        redirect = 1'b0;
        check("t7_next_addr", 64'(imem_req_addr), 64'hFFFF_FFF8);
        repeat (8) step();
        check("t7_first_pc", 64'(first_pop_pc), 64'hFFFF_FFF8);
        drain("t7_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
